// File: rtl/btle_phy_arbiter_pkg.sv
// Shared constants for the BTLE PHY arbiter: FSM encoding and the bit layout
// of the per-source TX/RX configuration words.
package btle_phy_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_TX_RUN  = 2'd2,
    ST_GUARD   = 2'd3
  } arb_state_e;

  localparam int PREAMBLE_W    = 8;
  localparam int ACCESS_ADDR_W = 32;
  localparam int MEM_ADDR_W    = 6;
  localparam int MEM_DATA_W    = 8;
  localparam int GUARD_CNT_W   = 8;

  // TX word, LSB first: channel, crc_init, access_address, preamble.
  function automatic int tx_cfg_w(input int cw, input int nw);
    return PREAMBLE_W + ACCESS_ADDR_W + cw + nw;
  endfunction

  function automatic int tx_crc_lsb(input int nw);
    return nw;
  endfunction

  function automatic int tx_aa_lsb(input int cw, input int nw);
    return nw + cw;
  endfunction

  function automatic int tx_pre_lsb(input int cw, input int nw);
    return nw + cw + ACCESS_ADDR_W;
  endfunction

  // RX word, LSB first: crc_init, channel, unique_bit_sequence.
  function automatic int rx_cfg_w(input int uw, input int nw, input int cw);
    return uw + nw + cw;
  endfunction

  function automatic int rx_ch_lsb(input int cw);
    return cw;
  endfunction

  function automatic int rx_ubs_lsb(input int cw, input int nw);
    return cw + nw;
  endfunction

endpackage

// File: rtl/btle_phy_arbiter_rr.sv
// Winner selection for the PHY arbiter: fixed priority (lowest index) or
// round-robin starting just after the last owner.
module btle_rr_arbiter #(
  parameter int NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] last_idx,
  input  logic                       rr_mode,
  output logic [NUM_SRC-1:0]         grant_oh,
  output logic [$clog2(NUM_SRC)-1:0] grant_idx,
  output logic                       valid
);

  localparam int IW = $clog2(NUM_SRC);

  always_comb begin
    int cand;
    cand      = 0;
    valid     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = rr_mode ? (int'(last_idx) + 1 + i) % NUM_SRC : i;
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        grant_idx = IW'(cand);
      end
    end
    grant_oh = valid ? (NUM_SRC'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/btle_phy_arbiter.sv
// Shares one BTLE PHY between several control sources (baremetal, link layer, ...).
// Owner's TX/RX fields are muxed straight to the PHY while it holds the grant.
module btle_phy_arbiter
  import btle_phy_arbiter_pkg::*;
#(
  parameter int    NUM_SRC                  = 2,
  parameter string ARB_MODE                 = "FIXED",
  parameter int    GUARD_CYCLES             = 4,
  parameter int    TX_TIMEOUT_CYCLES        = 65535,
  parameter int    CRC_STATE_BIT_WIDTH      = 24,
  parameter int    CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int    LEN_UNIQUE_BIT_SEQUENCE  = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_SRC-1:0]                   src_req,
  output logic [NUM_SRC-1:0]                   src_grant,
  input  logic [NUM_SRC-1:0]                   src_tx_start,
  input  logic [NUM_SRC*(40+CRC_STATE_BIT_WIDTH+CHANNEL_NUMBER_BIT_WIDTH)-1:0] src_tx_cfg,
  input  logic [NUM_SRC*6-1:0]                 src_tx_mem_addr,
  input  logic [NUM_SRC*8-1:0]                 src_tx_mem_data,
  input  logic [NUM_SRC*(LEN_UNIQUE_BIT_SEQUENCE+CHANNEL_NUMBER_BIT_WIDTH+CRC_STATE_BIT_WIDTH)-1:0] src_rx_cfg,
  input  logic [NUM_SRC*6-1:0]                 src_rx_mem_addr,
  output logic [7:0]                           tx_preamble,
  output logic [31:0]                          tx_access_address,
  output logic [CRC_STATE_BIT_WIDTH-1:0]       tx_crc_state_init_bit,
  output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0]  tx_channel_number,
  output logic [5:0]                           tx_pdu_octet_mem_addr,
  output logic [7:0]                           tx_pdu_octet_mem_data,
  output logic                                 tx_start,
  output logic                                 tx_crc_state_init_bit_load,
  output logic                                 tx_channel_number_load,
  output logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]   rx_unique_bit_sequence,
  output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0]  rx_channel_number,
  output logic [CRC_STATE_BIT_WIDTH-1:0]       rx_crc_state_init_bit,
  output logic [5:0]                           rx_pdu_octet_mem_addr,
  input  logic                                 tx_iq_valid_last,
  output logic [$clog2(NUM_SRC)-1:0]           owner_idx,
  output logic                                 busy,
  output logic                                 timeout_err,
  output logic                                 start_drop_err,
  input  logic                                 err_clr,
  output logic [1:0]                           fsm_state
);

  // Request/grant: a source raises src_req and holds it for as long as it wants
  // the PHY; src_grant (one-hot, registered) rises one cycle after winning and is
  // kept until the owner drops src_req outside a transmission, a TX ends with
  // src_req low, or the TX watchdog fires. Dropping src_req mid-TX is ignored.

  localparam int CW  = CRC_STATE_BIT_WIDTH;
  localparam int NW  = CHANNEL_NUMBER_BIT_WIDTH;
  localparam int UW  = LEN_UNIQUE_BIT_SEQUENCE;
  localparam int IW  = $clog2(NUM_SRC);
  localparam int TXW = tx_cfg_w(CW, NW);
  localparam int RXW = rx_cfg_w(UW, NW, CW);
  localparam int TCW = $clog2(TX_TIMEOUT_CYCLES);

  localparam int TX_CRC_LSB = tx_crc_lsb(NW);
  localparam int TX_AA_LSB  = tx_aa_lsb(CW, NW);
  localparam int TX_PRE_LSB = tx_pre_lsb(CW, NW);
  localparam int RX_CH_LSB  = rx_ch_lsb(CW);
  localparam int RX_UBS_LSB = rx_ubs_lsb(CW, NW);

  localparam bit                   RR_EN      = (ARB_MODE == "RR");
  localparam logic [TCW-1:0]         TX_LAST    = TCW'(TX_TIMEOUT_CYCLES - 1);
  localparam logic [GUARD_CNT_W-1:0] GUARD_LAST = GUARD_CNT_W'(GUARD_CYCLES - 1);

  arb_state_e               state_q, state_d;
  logic [IW-1:0]            owner_q, owner_d;
  logic [IW-1:0]            last_q, last_d;
  logic [NUM_SRC-1:0]       grant_q, grant_d;
  logic [GUARD_CNT_W-1:0]   guard_cnt_q, guard_cnt_d;
  logic [TCW-1:0]           tx_cnt_q, tx_cnt_d;
  logic                     timeout_q, drop_q;
  logic                     timeout_set, drop_set;

  logic [NUM_SRC-1:0]       win_oh;
  logic [IW-1:0]            win_idx;
  logic                     win_valid;
  logic                     owner_req, owner_start, phy_active;
  int                       tx_base, rx_base, mem_base;

  btle_rr_arbiter #(
    .NUM_SRC(NUM_SRC)
  ) u_arb (
    .req      (src_req),
    .last_idx (last_q),
    .rr_mode  (RR_EN),
    .grant_oh (win_oh),
    .grant_idx(win_idx),
    .valid    (win_valid)
  );

  assign owner_req   = src_req[owner_q];
  assign owner_start = src_tx_start[owner_q];
  assign tx_base     = int'(owner_q) * TXW;
  assign rx_base     = int'(owner_q) * RXW;
  assign mem_base    = int'(owner_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      last_q      <= IW'(NUM_SRC - 1);
      grant_q     <= '0;
      guard_cnt_q <= '0;
      tx_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      guard_cnt_q <= guard_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    grant_d     = grant_q;
    guard_cnt_d = guard_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    timeout_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_GRANTED;
          owner_d = win_idx;
          last_d  = win_idx;
          grant_d = win_oh;
        end
      end
      ST_GRANTED: begin
        // A start in the same cycle as the request drop still launches the TX.
        if (owner_start) begin
          state_d  = ST_TX_RUN;
          tx_cnt_d = '0;
        end else if (!owner_req) begin
          state_d     = ST_GUARD;
          grant_d     = '0;
          guard_cnt_d = '0;
        end
      end
      ST_TX_RUN: begin
        if (tx_iq_valid_last) begin
          if (owner_req) begin
            state_d = ST_GRANTED;
          end else begin
            state_d     = ST_GUARD;
            grant_d     = '0;
            guard_cnt_d = '0;
          end
        end else if (tx_cnt_q == TX_LAST) begin
          timeout_set = 1'b1;
          state_d     = ST_GUARD;
          grant_d     = '0;
          guard_cnt_d = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q == GUARD_LAST) begin
          state_d     = ST_IDLE;
          guard_cnt_d = '0;
        end else begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    phy_active                 = (state_q == ST_GRANTED) || (state_q == ST_TX_RUN);
    tx_start                   = (state_q == ST_GRANTED) && owner_start;
    tx_crc_state_init_bit_load = tx_start;
    tx_channel_number_load     = tx_start;
    drop_set                   = (state_q == ST_GRANTED) ? |(src_tx_start & ~grant_q)
                                                         : |src_tx_start;
    tx_preamble                = '0;
    tx_access_address          = '0;
    tx_crc_state_init_bit      = '0;
    tx_channel_number          = '0;
    tx_pdu_octet_mem_addr      = '0;
    tx_pdu_octet_mem_data      = '0;
    rx_unique_bit_sequence     = '0;
    rx_channel_number          = '0;
    rx_crc_state_init_bit      = '0;
    rx_pdu_octet_mem_addr      = '0;
    if (phy_active) begin
      tx_channel_number      = src_tx_cfg[tx_base +: NW];
      tx_crc_state_init_bit  = src_tx_cfg[tx_base + TX_CRC_LSB +: CW];
      tx_access_address      = src_tx_cfg[tx_base + TX_AA_LSB +: ACCESS_ADDR_W];
      tx_preamble            = src_tx_cfg[tx_base + TX_PRE_LSB +: PREAMBLE_W];
      tx_pdu_octet_mem_addr  = src_tx_mem_addr[mem_base * MEM_ADDR_W +: MEM_ADDR_W];
      tx_pdu_octet_mem_data  = src_tx_mem_data[mem_base * MEM_DATA_W +: MEM_DATA_W];
      rx_crc_state_init_bit  = src_rx_cfg[rx_base +: CW];
      rx_channel_number      = src_rx_cfg[rx_base + RX_CH_LSB +: NW];
      rx_unique_bit_sequence = src_rx_cfg[rx_base + RX_UBS_LSB +: UW];
      rx_pdu_octet_mem_addr  = src_rx_mem_addr[mem_base * MEM_ADDR_W +: MEM_ADDR_W];
    end
  end

  // Sticky errors: a new event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timeout_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      if (timeout_set)  timeout_q <= 1'b1;
      else if (err_clr) timeout_q <= 1'b0;
      if (drop_set)     drop_q    <= 1'b1;
      else if (err_clr) drop_q    <= 1'b0;
    end
  end

  assign src_grant      = grant_q;
  assign owner_idx      = owner_q;
  assign busy           = (state_q != ST_IDLE);
  assign timeout_err    = timeout_q;
  assign start_drop_err = drop_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_btle_phy_arbiter.sv
// Directed bench for btle_phy_arbiter: a 2-source FIXED instance with a short TX
// watchdog driven from a vector table, and a 3-source RR instance.
module tb_btle_phy_arbiter;

  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_G = 2'd1;
  localparam logic [1:0] S_T = 2'd2;
  localparam logic [1:0] S_D = 2'd3;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int step_id = 0;

  // ---------------- instance A: NUM_SRC=2, FIXED, timeout 16 ----------------
  logic         a_rst, a_iql, a_clr;
  logic [1:0]   a_req, a_start, a_grant, a_state;
  logic [139:0] a_tx_cfg;
  logic [11:0]  a_tx_maddr, a_rx_maddr;
  logic [15:0]  a_tx_mdata;
  logic [123:0] a_rx_cfg;
  logic [7:0]   a_pre, a_tmd;
  logic [31:0]  a_aa, a_ubs;
  logic [23:0]  a_crc, a_rcrc;
  logic [5:0]   a_ch, a_tma, a_rch, a_rma;
  logic         a_txs, a_crc_ld, a_ch_ld, a_busy, a_tmo, a_drp;
  logic [0:0]   a_owner;

  btle_phy_arbiter #(
    .NUM_SRC(2), .ARB_MODE("FIXED"), .GUARD_CYCLES(4), .TX_TIMEOUT_CYCLES(16),
    .CRC_STATE_BIT_WIDTH(24), .CHANNEL_NUMBER_BIT_WIDTH(6), .LEN_UNIQUE_BIT_SEQUENCE(32)
  ) dut_a (
    .clk(clk), .rst(a_rst), .src_req(a_req), .src_grant(a_grant),
    .src_tx_start(a_start), .src_tx_cfg(a_tx_cfg), .src_tx_mem_addr(a_tx_maddr),
    .src_tx_mem_data(a_tx_mdata), .src_rx_cfg(a_rx_cfg), .src_rx_mem_addr(a_rx_maddr),
    .tx_preamble(a_pre), .tx_access_address(a_aa), .tx_crc_state_init_bit(a_crc),
    .tx_channel_number(a_ch), .tx_pdu_octet_mem_addr(a_tma), .tx_pdu_octet_mem_data(a_tmd),
    .tx_start(a_txs), .tx_crc_state_init_bit_load(a_crc_ld), .tx_channel_number_load(a_ch_ld),
    .rx_unique_bit_sequence(a_ubs), .rx_channel_number(a_rch), .rx_crc_state_init_bit(a_rcrc),
    .rx_pdu_octet_mem_addr(a_rma), .tx_iq_valid_last(a_iql), .owner_idx(a_owner),
    .busy(a_busy), .timeout_err(a_tmo), .start_drop_err(a_drp), .err_clr(a_clr),
    .fsm_state(a_state)
  );

  // ---------------- instance B: NUM_SRC=3, RR ----------------
  logic         b_rst, b_iql, b_clr;
  logic [2:0]   b_req, b_start, b_grant;
  logic [209:0] b_tx_cfg;
  logic [17:0]  b_tx_maddr, b_rx_maddr;
  logic [23:0]  b_tx_mdata;
  logic [185:0] b_rx_cfg;
  logic [7:0]   b_pre, b_tmd;
  logic [31:0]  b_aa, b_ubs;
  logic [23:0]  b_crc, b_rcrc;
  logic [5:0]   b_ch, b_tma, b_rch, b_rma;
  logic         b_txs, b_crc_ld, b_ch_ld, b_busy, b_tmo, b_drp;
  logic [1:0]   b_owner, b_state;

  btle_phy_arbiter #(
    .NUM_SRC(3), .ARB_MODE("RR"), .GUARD_CYCLES(4), .TX_TIMEOUT_CYCLES(65535),
    .CRC_STATE_BIT_WIDTH(24), .CHANNEL_NUMBER_BIT_WIDTH(6), .LEN_UNIQUE_BIT_SEQUENCE(32)
  ) dut_b (
    .clk(clk), .rst(b_rst), .src_req(b_req), .src_grant(b_grant),
    .src_tx_start(b_start), .src_tx_cfg(b_tx_cfg), .src_tx_mem_addr(b_tx_maddr),
    .src_tx_mem_data(b_tx_mdata), .src_rx_cfg(b_rx_cfg), .src_rx_mem_addr(b_rx_maddr),
    .tx_preamble(b_pre), .tx_access_address(b_aa), .tx_crc_state_init_bit(b_crc),
    .tx_channel_number(b_ch), .tx_pdu_octet_mem_addr(b_tma), .tx_pdu_octet_mem_data(b_tmd),
    .tx_start(b_txs), .tx_crc_state_init_bit_load(b_crc_ld), .tx_channel_number_load(b_ch_ld),
    .rx_unique_bit_sequence(b_ubs), .rx_channel_number(b_rch), .rx_crc_state_init_bit(b_rcrc),
    .rx_pdu_octet_mem_addr(b_rma), .tx_iq_valid_last(b_iql), .owner_idx(b_owner),
    .busy(b_busy), .timeout_err(b_tmo), .start_drop_err(b_drp), .err_clr(b_clr),
    .fsm_state(b_state)
  );

  // ---------------- per-source configuration of instance A ----------------
  logic [7:0]  cfg_pre[2]   = '{8'h55, 8'hAA};
  logic [31:0] cfg_aa[2]    = '{32'h12345678, 32'h8E89BED6};
  logic [23:0] cfg_crc[2]   = '{24'h010203, 24'h555555};
  logic [5:0]  cfg_ch[2]    = '{6'd5, 6'd37};
  logic [5:0]  cfg_maddr[2] = '{6'h11, 6'h2A};
  logic [7:0]  cfg_mdata[2] = '{8'h22, 8'hC3};
  logic [31:0] cfg_ubs[2]   = '{32'hCAFEF00D, 32'h8E89BED6};
  logic [5:0]  cfg_rch[2]   = '{6'd7, 6'd37};
  logic [23:0] cfg_rcrc[2]  = '{24'hABCDEF, 24'h555555};
  logic [5:0]  cfg_raddr[2] = '{6'h03, 6'h3C};

  function automatic logic [83:0] exp_tx(input int o, input logic on);
    return on ? {cfg_pre[o], cfg_aa[o], cfg_crc[o], cfg_ch[o], cfg_maddr[o], cfg_mdata[o]} : 84'd0;
  endfunction

  function automatic logic [67:0] exp_rx(input int o, input logic on);
    return on ? {cfg_ubs[o], cfg_rch[o], cfg_rcrc[o], cfg_raddr[o]} : 68'd0;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual=%0h required=%0h", name, step_id, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] start;
    logic       iql;
    logic       clr;
    logic [1:0] st;
    logic [1:0] grant;
    logic       owner;
    logic       txs;
    logic       tmo;
    logic       drp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic [1:0] sp,
                              input logic iq, input logic cl, input logic [1:0] es,
                              input logic [1:0] eg, input logic eo, input logic et,
                              input logic etm, input logic ed);
    vec_t v;
    v = '{r, rq, sp, iq, cl, es, eg, eo, et, etm, ed};
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog step %0d actual=running required=finished", step_id);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    vec_t v;
    int   n;
    int   g;
    int   exp_own[4] = '{0, 1, 2, 0};
    logic on;

    a_rst = 1'b0; a_req = '0; a_start = '0; a_iql = 1'b0; a_clr = 1'b0;
    a_tx_cfg   = {cfg_pre[1], cfg_aa[1], cfg_crc[1], cfg_ch[1],
                  cfg_pre[0], cfg_aa[0], cfg_crc[0], cfg_ch[0]};
    a_tx_maddr = {cfg_maddr[1], cfg_maddr[0]};
    a_tx_mdata = {cfg_mdata[1], cfg_mdata[0]};
    a_rx_cfg   = {cfg_ubs[1], cfg_rch[1], cfg_rcrc[1], cfg_ubs[0], cfg_rch[0], cfg_rcrc[0]};
    a_rx_maddr = {cfg_raddr[1], cfg_raddr[0]};
    b_rst = 1'b0; b_req = '0; b_start = '0; b_iql = 1'b0; b_clr = 1'b0;
    b_tx_cfg = '0; b_tx_maddr = '0; b_tx_mdata = '0; b_rx_cfg = '0; b_rx_maddr = '0;

    //             rst   req    start  iql   clr  | st   grant  own   txs   tmo   drp
    vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b0, 1'b0, S_I, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 1'b0, S_I, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 1'b0, S_G, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b11, 2'b01, 1'b0, 1'b0, S_G, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b11, 2'b00, 1'b0, 1'b0, S_T, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 2'b10, 1'b0, 1'b0, S_T, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, S_T, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 2'b01, 2'b10, 1'b0, 1'b0, S_G, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, S_G, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 2'b10, 2'b00, 1'b0, 1'b0, S_D, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 2'b10, 2'b00, 1'b0, 1'b0, S_D, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 2'b10, 2'b00, 1'b0, 1'b0, S_D, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 2'b10, 2'b00, 1'b0, 1'b0, S_D, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 2'b10, 2'b00, 1'b0, 1'b1, S_I, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 2'b10, 2'b10, 1'b0, 1'b0, S_G, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 2'b00, 1'b1, 1'b0, S_T, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 2'b01, 1'b0, 1'b0, S_G, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 2'b10, 2'b11, 1'b0, 1'b1, S_G, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, S_T, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 2'b00, 2'b00, 1'b1, 1'b0, S_T, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, S_D, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1));

    step();
    step();

    foreach (vecs[i]) begin
      step_id = i;
      v = vecs[i];
      a_rst = v.rst_n; a_req = v.req; a_start = v.start; a_iql = v.iql; a_clr = v.clr;
      on = (v.st == S_G) || (v.st == S_T);
      @(negedge clk);
      chk("vec_state", a_state, v.st);
      chk("vec_grant", a_grant, v.grant);
      chk("vec_owner", a_owner, v.owner);
      chk("vec_busy", a_busy, v.st != S_I);
      chk("vec_tx_start", a_txs, v.txs);
      chk("vec_load_pulses", {a_crc_ld, a_ch_ld}, {v.txs, v.txs});
      chk("vec_timeout_err", a_tmo, v.tmo);
      chk("vec_start_drop_err", a_drp, v.drp);
      chk("vec_tx_fields", {a_pre, a_aa, a_crc, a_ch, a_tma, a_tmd}, exp_tx(int'(v.owner), on));
      chk("vec_rx_fields", {a_ubs, a_rch, a_rcrc, a_rma}, exp_rx(int'(v.owner), on));
      @(posedge clk);
      #1;
    end
    a_iql = 1'b0; a_clr = 1'b0; a_start = '0;

    // TX watchdog: 16 TX_RUN cycles with no end-of-packet, then GUARD + sticky error.
    step_id = 100;
    a_req = 2'b01;
    n = 0;
    while (a_state != S_G && n < 20) begin step(); n++; end
    chk("tmo_reach_granted", a_state, S_G);
    chk("tmo_owner", a_owner, 1'b0);
    a_start = 2'b01; a_clr = 1'b1;
    step();
    a_start = 2'b00; a_clr = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step_id = 200 + c;
      chk("tmo_in_tx_run", a_state, S_T);
      chk("tmo_not_yet", a_tmo, 1'b0);
      step();
    end
    step_id = 300;
    chk("tmo_state_guard", a_state, S_D);
    chk("tmo_grant_zero", a_grant, 2'b00);
    chk("tmo_err_set", a_tmo, 1'b1);
    chk("tmo_drop_cleared", a_drp, 1'b0);
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    chk("tmo_err_clr", a_tmo, 1'b0);

    // Reset in the middle of a transmission by source 1, with a sticky error set.
    step_id = 400;
    a_req = 2'b10;
    n = 0;
    while (a_state != S_G && n < 20) begin step(); n++; end
    chk("rst_reach_granted", a_state, S_G);
    chk("rst_owner_one", a_owner, 1'b1);
    a_start = 2'b10;
    step();
    step();
    a_start = 2'b00;
    chk("rst_pre_tx_run", a_state, S_T);
    chk("rst_pre_drop", a_drp, 1'b1);
    a_rst = 1'b0;
    step();
    chk("rst_state", a_state, S_I);
    chk("rst_grant", a_grant, 2'b00);
    chk("rst_owner", a_owner, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_errors", {a_tmo, a_drp}, 2'b00);
    chk("rst_tx_pulses", {a_txs, a_crc_ld, a_ch_ld}, 3'b000);
    chk("rst_tx_fields", {a_pre, a_aa, a_crc, a_ch, a_tma, a_tmd}, exp_tx(0, 1'b0));
    chk("rst_rx_fields", {a_ubs, a_rch, a_rcrc, a_rma}, exp_rx(0, 1'b0));
    a_rst = 1'b1; a_req = 2'b00;

    // Round-robin with all three sources requesting; owners rotate 0,1,2,0.
    b_req = 3'b111;
    step();
    b_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step_id = 500 + k;
      n = 0;
      while (b_state != S_G && n < 20) begin step(); n++; end
      chk("rr_grant_latency", n, 1);
      chk("rr_owner", b_owner, exp_own[k]);
      chk("rr_grant_onehot", b_grant, 3'b001 << exp_own[k]);
      if (k < 3) begin
        b_req[exp_own[k]] = 1'b0;
        step();
        b_req = 3'b111;
        chk("rr_guard_grant", b_grant, 3'b000);
        g = 0;
        while (b_state == S_D && g < 300) begin step(); g++; end
        chk("rr_guard_cycles", g, 4);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
